// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: word, valid/ready and error pulses.
// With UART_RX_PARITY_EN defined the bundle also carries parity_err.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  frame_err;
  logic                  overrun;
`ifdef UART_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    input  rx_ready,
    output rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );

  modport slave (
    output rx_ready,
    input  rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver, 16x oversampled, mid-bit sampling, valid/ready word output.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | half a bit into the start bit, confirm it is still low
// DATA   | one sample per bit period, shifted in LSB first
// PARITY | parity bit sample (only with UART_RX_PARITY_EN)
// STOP   | stop bit sample, deliver word or flag a framing error
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      ena,
  input  logic      rx_signal,
  uart_rx_if.master rx_bus
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_FULL  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  rx_meta, rx_s, rx_p;
  logic [DIV_W-1:0]      tick_cnt;
  logic [OS_W-1:0]       os_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q, frame_err_q, overrun_q;
  logic                  tick;
  logic                  sample;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, parity_err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
    end else begin
      rx_meta <= rx_signal;
      rx_s    <= rx_meta;
      rx_p    <= rx_s;
    end
  end

  assign tick   = (tick_cnt == DIV_LAST);
  assign sample = tick && (os_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && rx_bus.rx_ready)
        rx_valid_q <= 1'b0;

      if (!ena || state == IDLE || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      if (tick && os_cnt != '0)
        os_cnt <= os_cnt - 1'b1;

      if (!ena) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_p && !rx_s) begin
              state  <= START;
              os_cnt <= OS_HALF;
            end
          end
          START: begin
            if (sample) begin
              os_cnt  <= OS_FULL;
              bit_cnt <= BIT_LAST;
              state   <= rx_s ? IDLE : DATA;
            end
          end
          DATA: begin
            if (sample) begin
              shreg  <= {rx_s, shreg[DATA_WIDTH-1:1]};
              os_cnt <= OS_FULL;
              if (bit_cnt == '0)
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              else
                bit_cnt <= bit_cnt - 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sample) begin
              par_bit <= rx_s;
              os_cnt  <= OS_FULL;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            if (sample) begin
              state <= IDLE;
              if (!rx_s) begin
                frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if ((^shreg ^ par_bit) != PARITY_ODD) begin
                parity_err_q <= 1'b1;
`endif
              end else begin
                // an accepting handshake this cycle frees the slot, so no overrun
                rx_data_q  <= shreg;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q && !rx_bus.rx_ready;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx_bus.rx_data   = rx_data_q;
  assign rx_bus.rx_valid  = rx_valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.parity_err = parity_err_q;
`endif

endmodule
